// File: rtl/ram_bist_ctrl.sv
// Memory BIST initiator/checker: two-pass march (pattern^addr, then its inverse)
// over a single-port-pair RAM, with a latency-matched expected-data compare pipe.
module ram_bist_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [DATA_WIDTH-1:0] pattern_i,
   output logic                  we_o,
   output logic [ADDR_WIDTH-1:0] wr_addr_o,
   output logic [DATA_WIDTH-1:0] wr_din_o,
   output logic                  re_o,
   output logic [ADDR_WIDTH-1:0] rd_addr_o,
   input  logic [DATA_WIDTH-1:0] rd_dout_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  pass_o,
   output logic [ADDR_WIDTH+1:0] err_count_o,
   output logic [ADDR_WIDTH-1:0] fail_addr_o
);

   localparam logic [ADDR_WIDTH-1:0] A_LAST  = '1;
   localparam logic [ADDR_WIDTH-1:0] A_ONE   = 1;
   localparam logic [ADDR_WIDTH+1:0] ERR_ONE = 1;
   localparam logic [2:0]            D_LAST  = 3'(RD_LATENCY - 1);

   typedef enum logic [2:0] {IDLE, WR0, RD0, DR0, WR1, RD1, DR1, FIN} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] a_q, a_d;
   logic [2:0]            dcnt_q, dcnt_d;
   logic [DATA_WIDTH-1:0] pat_q, pat_d;
   logic                  we_q, we_d, re_q, re_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
   logic [DATA_WIDTH-1:0] wr_din_q, wr_din_d;
   logic                  busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [ADDR_WIDTH+1:0] err_q, err_d;
   logic [ADDR_WIDTH-1:0] fail_q, fail_d;

   logic [RD_LATENCY:1]                 vld_pipe_q;
   logic [RD_LATENCY:1][DATA_WIDTH-1:0] exp_pipe_q;
   logic [RD_LATENCY:1][ADDR_WIDTH-1:0] adr_pipe_q;
   logic [DATA_WIDTH-1:0]               rd_exp;
   logic                                mismatch;

   function automatic logic [DATA_WIDTH-1:0] march_data(input logic [DATA_WIDTH-1:0] p,
                                                        input logic inv,
                                                        input logic [ADDR_WIDTH-1:0] a);
      logic [DATA_WIDTH-1:0] w;
      w = p ^ DATA_WIDTH'(a);
      return inv ? ~w : w;
   endfunction

   // Expected word for the read issued this cycle; travels with it down the pipe.
   assign rd_exp   = march_data(pat_q, state_q == RD1, rd_addr_q);
   assign mismatch = vld_pipe_q[RD_LATENCY] && (rd_dout_i != exp_pipe_q[RD_LATENCY]);

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      dcnt_d    = dcnt_q;
      pat_d     = pat_q;
      busy_d    = busy_q;
      done_d    = done_q;
      pass_d    = pass_q;
      err_d     = err_q;
      fail_d    = fail_q;
      we_d      = 1'b0;
      re_d      = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_din_d  = wr_din_q;
      rd_addr_d = rd_addr_q;

      if (mismatch) begin
         if (err_q == '0) fail_d = adr_pipe_q[RD_LATENCY];
         err_d = err_q + ERR_ONE;
      end

      case (state_q)
         IDLE: if (start_i) begin
            pat_d   = pattern_i;
            err_d   = '0;
            fail_d  = '0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            busy_d  = 1'b1;
            a_d     = '0;
            state_d = WR0;
         end
         WR0, WR1: begin
            if (a_q == A_LAST) begin
               a_d     = '0;
               state_d = (state_q == WR0) ? RD0 : RD1;
            end else begin
               a_d = a_q + A_ONE;
            end
         end
         RD0, RD1: begin
            if (a_q == A_LAST) begin
               a_d     = '0;
               dcnt_d  = '0;
               state_d = (state_q == RD0) ? DR0 : DR1;
            end else begin
               a_d = a_q + A_ONE;
            end
         end
         DR0, DR1: begin
            if (dcnt_q == D_LAST) begin
               state_d = (state_q == DR0) ? WR1 : FIN;
               if (state_q == DR1) begin
                  // The last compare lands on this same edge, so err_d is final.
                  busy_d = 1'b0;
                  done_d = 1'b1;
                  pass_d = (err_d == '0);
               end
            end else begin
               dcnt_d = dcnt_q + 3'd1;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Port values are registered off the next state so they align with it.
      case (state_d)
         WR0, WR1: begin
            we_d      = 1'b1;
            wr_addr_d = a_d;
            wr_din_d  = march_data(pat_d, state_d == WR1, a_d);
         end
         RD0, RD1: begin
            re_d      = 1'b1;
            rd_addr_d = a_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         a_q       <= '0;
         dcnt_q    <= '0;
         pat_q     <= '0;
         we_q      <= 1'b0;
         re_q      <= 1'b0;
         wr_addr_q <= '0;
         wr_din_q  <= '0;
         rd_addr_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         err_q     <= '0;
         fail_q    <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         dcnt_q    <= dcnt_d;
         pat_q     <= pat_d;
         we_q      <= we_d;
         re_q      <= re_d;
         wr_addr_q <= wr_addr_d;
         wr_din_q  <= wr_din_d;
         rd_addr_q <= rd_addr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         err_q     <= err_d;
         fail_q    <= fail_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_pipe_q <= '0;
         exp_pipe_q <= '0;
         adr_pipe_q <= '0;
      end else begin
         vld_pipe_q[1] <= re_q;
         exp_pipe_q[1] <= rd_exp;
         adr_pipe_q[1] <= rd_addr_q;
         for (int i = 2; i <= RD_LATENCY; i++) begin
            vld_pipe_q[i] <= vld_pipe_q[i-1];
            exp_pipe_q[i] <= exp_pipe_q[i-1];
            adr_pipe_q[i] <= adr_pipe_q[i-1];
         end
      end
   end

   assign we_o        = we_q;
   assign wr_addr_o   = wr_addr_q;
   assign wr_din_o    = wr_din_q;
   assign re_o        = re_q;
   assign rd_addr_o   = rd_addr_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign pass_o      = pass_q;
   assign err_count_o = err_q;
   assign fail_addr_o = fail_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: RAM models with fault injection, write/read/result scoreboards.
module tb_ram_bist_ctrl;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst_n;
   logic start1, start3;
   logic [7:0] pattern;
   always #5 clk = ~clk;

   logic       we1, re1, busy1, done1, pass1;
   logic [3:0] wa1, ra1, fail1;
   logic [7:0] wd1, dout1;
   logic [5:0] err1;
   logic       we3, re3, busy3, done3, pass3;
   logic [3:0] wa3, ra3, fail3;
   logic [7:0] wd3, dout3;
   logic [5:0] err3;

   ram_bist_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_LATENCY(1)) u1 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .pattern_i(pattern),
      .we_o(we1), .wr_addr_o(wa1), .wr_din_o(wd1), .re_o(re1), .rd_addr_o(ra1),
      .rd_dout_i(dout1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
      .err_count_o(err1), .fail_addr_o(fail1));

   ram_bist_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_LATENCY(3)) u3 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start3), .pattern_i(pattern),
      .we_o(we3), .wr_addr_o(wa3), .wr_din_o(wd3), .re_o(re3), .rd_addr_o(ra3),
      .rd_dout_i(dout3), .busy_o(busy3), .done_o(done3), .pass_o(pass3),
      .err_count_o(err3), .fail_addr_o(fail3));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // RAM models; idle read slots return 00 so a mistimed compare shows up as an error.
   logic [7:0] mem1 [DEPTH];
   logic [7:0] mem3 [DEPTH];
   logic [7:0] p3a, p3b;
   int stuck1 = -1, stuck3 = -1;
   bit zero1 = 1'b0;

   function automatic logic [7:0] fault(input logic [7:0] d, input logic [3:0] a,
                                        input int stuck, input bit zero);
      if (zero) return 8'h00;
      if (int'(a) == stuck) return {d[7:1], 1'b0};
      return d;
   endfunction

   always @(posedge clk) begin
      if (we1) mem1[wa1] <= wd1;
      dout1 <= re1 ? fault(mem1[ra1], ra1, stuck1, zero1) : 8'h00;
   end

   always @(posedge clk) begin
      if (we3) mem3[wa3] <= wd3;
      p3a   <= re3 ? fault(mem3[ra3], ra3, stuck3, 1'b0) : 8'h00;
      p3b   <= p3a;
      dout3 <= p3b;
   end

   typedef struct {logic [3:0] a; logic [7:0] d;} wr_t;
   typedef struct {int cyc; logic [5:0] err; logic [3:0] fail; logic pass;} res_t;
   wr_t        wq[$];
   logic [3:0] rq[$];
   res_t       resq1[$];
   res_t       resq3[$];

   function automatic logic [7:0] wexp(input logic [7:0] p, input bit inv, input int a);
      logic [7:0] w;
      w = p ^ 8'(a);
      return inv ? ~w : w;
   endfunction

   task automatic push_run1(input logic [7:0] p, input int cyc, input int err,
                            input int fail, input bit pass);
      for (int ph = 0; ph < 2; ph++)
         for (int a = 0; a < DEPTH; a++) begin
            wq.push_back('{4'(a), wexp(p, ph[0], a)});
            rq.push_back(4'(a));
         end
      resq1.push_back('{cyc, 6'(err), 4'(fail), pass});
   endtask

   // Monitor for the latency-1 instance: write/read traffic and final results.
   int   bcnt1 = 0;
   logic done1_p = 1'b0;
   always @(negedge clk) begin
      wr_t  w;
      res_t r;
      logic [3:0] ea;
      if (!rst_n) bcnt1 = 0;
      else begin
         if (we1 || re1) chk("we_re_excl", {31'b0, we1 & re1}, 0);
         if (busy1) bcnt1++;
         if (we1) begin
            if (wq.size() == 0) chk("wr_unexp", {31'b0, we1}, 0);
            else begin
               w = wq.pop_front();
               chk("wr_addr", {28'b0, wa1}, {28'b0, w.a});
               chk("wr_din", {24'b0, wd1}, {24'b0, w.d});
            end
         end
         if (re1) begin
            if (rq.size() == 0) chk("rd_unexp", {31'b0, re1}, 0);
            else begin
               ea = rq.pop_front();
               chk("rd_addr", {28'b0, ra1}, {28'b0, ea});
            end
         end
         if (done1 && !done1_p) begin
            if (resq1.size() == 0) chk("res_unexp", {31'b0, done1}, 0);
            else begin
               r = resq1.pop_front();
               chk("busy_cycles", bcnt1, r.cyc);
               chk("err_count", {26'b0, err1}, {26'b0, r.err});
               chk("fail_addr", {28'b0, fail1}, {28'b0, r.fail});
               chk("pass", {31'b0, pass1}, {31'b0, r.pass});
               chk("busy_at_done", {31'b0, busy1}, 0);
            end
            bcnt1 = 0;
         end
      end
      done1_p = done1;
   end

   int   bcnt3 = 0;
   logic done3_p = 1'b0;
   always @(negedge clk) begin
      res_t r;
      if (!rst_n) bcnt3 = 0;
      else begin
         if (we3 || re3) chk("we_re_excl3", {31'b0, we3 & re3}, 0);
         if (busy3) bcnt3++;
         if (done3 && !done3_p) begin
            if (resq3.size() == 0) chk("res3_unexp", {31'b0, done3}, 0);
            else begin
               r = resq3.pop_front();
               chk("busy_cycles3", bcnt3, r.cyc);
               chk("err_count3", {26'b0, err3}, {26'b0, r.err});
               chk("fail_addr3", {28'b0, fail3}, {28'b0, r.fail});
               chk("pass3", {31'b0, pass3}, {31'b0, r.pass});
            end
            bcnt3 = 0;
         end
      end
      done3_p = done3;
   end

   task automatic launch1(input logic [7:0] p);
      @(negedge clk); pattern = p; start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
   endtask

   task automatic launch3(input logic [7:0] p);
      @(negedge clk); pattern = p; start3 = 1'b1;
      @(negedge clk); start3 = 1'b0;
   endtask

   task automatic wait_done1(input int maxc);
      int n = 0;
      while (!done1 && n < maxc) begin @(negedge clk); n++; end
      chk("done1_seen", {31'b0, done1}, 1);
      @(negedge clk);
   endtask

   task automatic wait_done3(input int maxc);
      int n = 0;
      while (!done3 && n < maxc) begin @(negedge clk); n++; end
      chk("done3_seen", {31'b0, done3}, 1);
      @(negedge clk);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; pattern = 8'hA5;
      #1;
      chk("rst_we", {31'b0, we1}, 0);
      chk("rst_re", {31'b0, re1}, 0);
      chk("rst_busy", {31'b0, busy1}, 0);
      chk("rst_done", {31'b0, done1}, 0);
      chk("rst_pass", {31'b0, pass1}, 0);
      chk("rst_wr_addr", {28'b0, wa1}, 0);
      chk("rst_wr_din", {24'b0, wd1}, 0);
      chk("rst_rd_addr", {28'b0, ra1}, 0);
      chk("rst_err", {26'b0, err1}, 0);
      chk("rst_fail", {28'b0, fail1}, 0);
      chk("rst_busy3", {31'b0, busy3}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Clean RAM, pattern A5
      push_run1(8'hA5, 66, 0, 0, 1'b1);
      launch1(8'hA5);
      wait_done1(200);
      chk("mem15_after_wr1", {24'b0, mem1[15]}, 32'h55);
      chk("mem0_after_wr1", {24'b0, mem1[0]}, 32'h5A);

      // Bit0 stuck-at-0 at address 4
      stuck1 = 4;
      push_run1(8'hA5, 66, 1, 4, 1'b0);
      launch1(8'hA5);
      wait_done1(200);
      stuck1 = -1;

      // Every read returns 00
      zero1 = 1'b1;
      push_run1(8'hA5, 66, 32, 0, 1'b0);
      launch1(8'hA5);
      wait_done1(200);

      // Reset mid-test during RD0 at a=7, with errors already accumulated
      push_run1(8'hA5, 66, 0, 0, 1'b1);
      launch1(8'hA5);
      n = 0;
      while (!(re1 && ra1 == 4'd7) && n < 100) begin @(negedge clk); n++; end
      chk("reach_rd7", {31'b0, re1 && ra1 == 4'd7}, 1);
      chk("err_before_rst", {31'b0, err1 != 6'd0}, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_we", {31'b0, we1}, 0);
      chk("mid_rst_re", {31'b0, re1}, 0);
      chk("mid_rst_busy", {31'b0, busy1}, 0);
      chk("mid_rst_done", {31'b0, done1}, 0);
      chk("mid_rst_err", {26'b0, err1}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      wq.delete(); rq.delete(); resq1.delete();
      zero1 = 1'b0;
      push_run1(8'hA5, 66, 0, 0, 1'b1);
      launch1(8'hA5);
      wait_done1(200);

      // Start re-pulsed while busy and pattern changed mid-test: both ignored
      push_run1(8'hA5, 66, 0, 0, 1'b1);
      launch1(8'hA5);
      repeat (10) @(negedge clk);
      start1 = 1'b1; pattern = 8'h3C;
      @(negedge clk);
      start1 = 1'b0;
      wait_done1(200);
      pattern = 8'hA5;

      // RD_LATENCY=3: clean, then stuck at address 15 (caught in RD1, through DR1 drain)
      resq3.push_back('{70, 6'd0, 4'd0, 1'b1});
      launch3(8'hA5);
      wait_done3(200);
      stuck3 = 15;
      resq3.push_back('{70, 6'd1, 4'd15, 1'b0});
      launch3(8'hA5);
      wait_done3(200);

      repeat (3) @(negedge clk);
      chk("wq_drained", wq.size(), 0);
      chk("rq_drained", rq.size(), 0);
      chk("resq1_drained", resq1.size(), 0);
      chk("resq3_drained", resq3.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
- Self-contained traffic initiator and checker for the single-port-pair RAM (we/wr_addr/wr_din, re/rd_addr/rd_dout).
- Drives the RAM's write and read ports through a two-pass march: write all addresses, then read and compare; write all addresses with inverted data, then read and compare.
- Reports pass/fail, error count and first failing address.
- Sits next to the RAM as the initiator end of the same interface, replacing bench-driven traffic for power-on and in-system memory test.

Parameters:
- ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, RAM data width; must be >= ADDR_WIDTH.
- RD_LATENCY, 1, clock edges from the edge sampling re=1 to the edge at which rd_dout is valid for sampling; range 1..4.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled only in IDLE; 1 launches a test.
- pattern  in  DATA_WIDTH  base data word; captured on the accepted start edge.
- we  out  1  RAM write enable.
- wr_addr  out  ADDR_WIDTH  RAM write address.
- wr_din  out  DATA_WIDTH  RAM write data.
- re  out  1  RAM read enable.
- rd_addr  out  ADDR_WIDTH  RAM read address.
- rd_dout  in  DATA_WIDTH  RAM read data.
- busy  out  1  high while a test is running.
- done  out  1  sticky; high after completion until the next accepted start or reset.
- pass  out  1  valid when done=1; 1 iff err_count==0.
- err_count  out  ADDR_WIDTH+2  number of mismatching reads; maximum 2*DEPTH, so it cannot saturate.
- fail_addr  out  ADDR_WIDTH  address of the first mismatch; holds 0 if there is none.

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous): state=IDLE; we, re, busy, done and pass are 0; wr_addr, wr_din, rd_addr, err_count and fail_addr are 0; the expected-data pipe is cleared.
- States: IDLE, WR0, RD0, DR0, WR1, RD1, DR1, FIN.
- IDLE: start=1 at an edge captures pattern, clears err_count, fail_addr, done and pass, and sets busy. It enters WR0 with address counter a=0.
- WR0: one write per cycle: we=1, wr_addr=a, wr_din=pattern^zext(a). a increments; after a=DEPTH-1 the block goes to RD0 with a=0.
- RD0: one read per cycle: re=1, rd_addr=a. Expected data pattern^zext(a) and address a enter a RD_LATENCY-deep valid/expected/address pipe. After a=DEPTH-1 the block goes to DR0.
- DR0: holds for RD_LATENCY cycles with re=0 so the pipe drains, then goes to WR1.
- WR1, RD1, DR1: same as WR0, RD0, DR0 but with data ~(pattern^zext(a)).
- FIN: lasts one cycle. busy goes 0; done and pass are set together in this cycle and hold. The block then returns to IDLE.
- Compare:
  - When the pipe output is valid, rd_dout is compared with the expected word at that edge.
  - A mismatch increments err_count.
  - If err_count was 0, fail_addr captures the pipe address.
- we and re are never high in the same cycle. No reads are issued during write phases and no writes during read phases.
- Write-to-read ordering: the first RD0 read follows the last WR0 write by one cycle; the RAM must return written data under that spacing.
- Timing: busy is high for 4*DEPTH + 2*RD_LATENCY cycles, then FIN.
- start while busy or in FIN is ignored. start held high in IDLE after done relaunches immediately.
- pattern changes during a test have no effect.
- Reset mid-test: an immediate return to IDLE with all reset values. No partial results are retained.
- Address wrap: the counter is ADDR_WIDTH+1 bits or uses an explicit terminal compare. The block must never issue address 0 twice in a phase.

Test Plan:
- Clean RAM, ADDR_WIDTH=4, DATA_WIDTH=8, RD_LATENCY=1, pattern=8'hA5, 1-cycle start pulse:
  - WR0 writes addr0=A5, addr3=A6, addr15=AA; WR1 writes addr0=5A.
  - busy high exactly 66 cycles; then done=1, pass=1, err_count=0, fail_addr=0.
- Bench RAM model with bit0 stuck-at-0 at address 4, pattern=A5:
  - RD0 expects A1 and reads A0, which is a mismatch; RD1 expects 5E and reads 5E.
  - Result: done=1, pass=0, err_count=1, fail_addr=4.
- Model returning 8'h00 for every read:
  - err_count=32 (2*DEPTH, no wrap), fail_addr=0, pass=0.
- Reset mid-test: rst=0 for 2 cycles during RD0 at a=7:
  - we, re, busy, done, err_count all 0 immediately and asynchronously.
  - A fresh start then completes with pass=1.
- start re-pulsed while busy, and pattern changed to 8'h3C mid-test:
  - Both ignored; all writes use A5 data; completion timing unchanged at 66 cycles.
- RD_LATENCY=3 with a matching 3-cycle RAM model:
  - busy for 70 cycles; pass=1; no compare occurs outside the drained pipe window.
  - A stuck fault at address 15 is detected, confirming DR0/DR1 drain before the phase change.
